// File: rtl/health_monitor.sv
// health_monitor: per-channel ADC threshold checker with persistence filter, sticky flags and Wishbone register file.
module health_monitor #(
  parameter logic [2:0]  PERSIST_COUNT       = 3'd4,
  parameter logic [31:0] UNSAFE_MASK_DEFAULT = 32'h0000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [15:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        adc_strb,
  input  logic [4:0]  adc_channel,
  input  logic [11:0] adc_data,
  output logic [31:0] sys_health,
  output logic        unsafe_sys_health,
  output logic        alarm_strb
);
  logic [11:0] lo [32];
  logic [11:0] hi [32];
  logic [2:0]  cnt [32];
  logic [31:0] sticky, mask, set, clr;
  logic        en, s1_v, req, wr, viol, trip;
  logic [4:0]  s1_ch;
  logic [11:0] s1_d, s1_lo, s1_hi;
  logic [2:0]  cnt_cur;
  logic [15:0] rd;

  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr      = req & wb_we_i;
  assign viol    = s1_v && (s1_d < s1_lo || s1_d > s1_hi);
  assign cnt_cur = cnt[s1_ch];
  assign trip    = viol && cnt_cur == PERSIST_COUNT - 3'd1;
  assign set     = trip ? 32'd1 << s1_ch : 32'd0;
  assign clr     = !wr ? 32'd0 :
                   wb_adr_i == 16'd68 ? {16'h0, wb_dat_i} :
                   wb_adr_i == 16'd69 ? {wb_dat_i, 16'h0} : 32'd0;

  always_comb
    rd = wb_adr_i < 16'd32 ? {4'h0, lo[wb_adr_i[4:0]]} :
         wb_adr_i < 16'd64 ? {4'h0, hi[wb_adr_i[4:0]]} :
         wb_adr_i == 16'd64 ? sys_health[15:0] :
         wb_adr_i == 16'd65 ? sys_health[31:16] :
         wb_adr_i == 16'd66 ? mask[15:0] :
         wb_adr_i == 16'd67 ? mask[31:16] :
         wb_adr_i == 16'd68 ? sticky[15:0] :
         wb_adr_i == 16'd69 ? sticky[31:16] :
         wb_adr_i == 16'd70 ? {15'h0, en} : 16'h0;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 32; i++) begin
        lo[i]  <= 12'h000;
        hi[i]  <= 12'hfff;
        cnt[i] <= 3'd0;
      end
      sticky            <= 32'h0;
      mask              <= UNSAFE_MASK_DEFAULT;
      en                <= 1'b1;
      s1_v              <= 1'b0;
      s1_ch             <= 5'd0;
      s1_d              <= 12'h0;
      s1_lo             <= 12'h0;
      s1_hi             <= 12'h0;
      wb_ack_o          <= 1'b0;
      wb_dat_o          <= 16'h0;
      sys_health        <= 32'hffff_ffff;
      unsafe_sys_health <= 1'b0;
      alarm_strb        <= 1'b0;
    end else begin
      wb_ack_o <= req;
      if (req) wb_dat_o <= rd;
      if (wr) begin
        if (wb_adr_i < 16'd32) lo[wb_adr_i[4:0]] <= wb_dat_i[11:0];
        else if (wb_adr_i < 16'd64) hi[wb_adr_i[4:0]] <= wb_dat_i[11:0];
        if (wb_adr_i == 16'd66) mask[15:0] <= wb_dat_i;
        if (wb_adr_i == 16'd67) mask[31:16] <= wb_dat_i;
        if (wb_adr_i == 16'd70) en <= wb_dat_i[0];
      end
      // thresholds are captured here, so a write in the strobe cycle applies to the next sample
      s1_v  <= adc_strb & en;
      s1_ch <= adc_channel;
      s1_d  <= adc_data;
      s1_lo <= lo[adc_channel];
      s1_hi <= hi[adc_channel];
      if (s1_v) begin
        cnt[s1_ch] <= !viol ? 3'd0 : cnt_cur == PERSIST_COUNT ? cnt_cur : cnt_cur + 3'd1;
        if (!viol) sys_health[s1_ch] <= 1'b1;
        else if (trip) sys_health[s1_ch] <= 1'b0;
      end
      alarm_strb        <= trip & sys_health[s1_ch];
      sticky            <= (sticky & ~clr) | set;
      unsafe_sys_health <= |(~sys_health & mask);
    end
  end
endmodule

// File: doc/health_monitor.md
Name: health_monitor

Overview:
Upstream stage of the power manager. It consumes the ADC sample stream and compares each channel's sample against Wishbone-programmable low/high thresholds. A channel is declared unhealthy only after a configurable number of consecutive violations. The block produces the 32-bit sys_health vector and the masked unsafe_sys_health flag that the power manager uses for its post-power-up check and crash handling.

Parameters:
PERSIST_COUNT, 3'd4, consecutive out-of-range samples required to clear a channel's health bit (legal range 1..7)
UNSAFE_MASK_DEFAULT, 32'h0000_0000, reset value of the unsafe mask (channels that can raise unsafe_sys_health)

Ports:
wb_clk_i  in  1  system clock; only clock in the block
wb_rst_i  in  1  synchronous, active-high reset
wb_cyc_i  in  1  Wishbone cycle
wb_stb_i  in  1  Wishbone strobe
wb_we_i  in  1  Wishbone write enable
wb_adr_i  in  16  Wishbone word address
wb_dat_i  in  16  Wishbone write data
wb_dat_o  out  16  Wishbone read data
wb_ack_o  out  1  Wishbone acknowledge
adc_strb  in  1  one-cycle pulse: adc_channel/adc_data valid
adc_channel  in  5  channel index 0..31
adc_data  in  12  unsigned sample
sys_health  out  32  bit i = 1: channel i healthy
unsafe_sys_health  out  1  registered OR of (~sys_health & unsafe_mask)
alarm_strb  out  1  one-cycle pulse when any health bit goes 1->0

Behaviour:
- Reset values:
  - sys_health = 32'hffff_ffff; unsafe_sys_health = 0; alarm_strb = 0; wb_ack_o = 0.
  - All low thresholds = 12'h000; all high thresholds = 12'hfff.
  - All violation counters = 0; sticky = 0; enable = 1; unsafe_mask = UNSAFE_MASK_DEFAULT.
- Wishbone:
  - wb_ack_o pulses for one cycle, one cycle after cyc&stb&~ack. Back-to-back requests therefore ack every other cycle.
  - Read data is selected at ack time and held until the next access.
  - Register map (word addresses):
    - 0..31: low threshold ch0..31, bits [11:0].
    - 32..63: high threshold ch0..31, bits [11:0].
    - 64/65: sys_health [15:0]/[31:16], read-only.
    - 66/67: unsafe_mask [15:0]/[31:16], read/write.
    - 68/69: sticky violation [15:0]/[31:16]. Read returns the bits; a write clears every bit where wb_dat_i=1.
    - 70: bit0 = enable.
    - Other addresses: ack, read 0, writes ignored.
- Sample pipeline (accepts one sample every cycle):
  - Stage 1 (cycle N+1): latch channel and data; read lo/hi thresholds. A threshold write landing in the same cycle takes effect from the next sample.
  - Stage 2 (cycle N+2): violation = data < lo OR data > hi (unsigned compare).
    - Violation: counter[ch] increments, saturating at PERSIST_COUNT. On the cycle the counter reaches PERSIST_COUNT, sys_health[ch] goes 0 and sticky[ch] goes 1. alarm_strb pulses if the bit was previously 1.
    - In range: counter[ch] goes 0 and sys_health[ch] goes 1.
  - Stage 3 (cycle N+3): unsafe_sys_health updates.
- Programmed lo > hi: every sample violates; no special handling.
- enable = 0: strobes are dropped at stage 1. Counters, health and sticky bits hold. Samples already in flight complete.
- Simultaneous events:
  - Sticky clear and new violation on the same bit in the same cycle: set wins.
  - Mask write: unsafe_sys_health reflects the new mask one cycle after the ack.
- Reset mid-pipeline discards in-flight samples; all state returns to reset values.

Test Plan:
1. Reset, then read addr 64/65 -> 16'hffff each. unsafe_sys_health=0. Read addr 32 -> 12'hfff.
2. Program ch3 lo=12'h100, hi=12'h200; send 4 samples of 12'h250 on ch3, one per cycle -> sys_health[3]=0 two cycles after the 4th strobe; alarm_strb pulses once; sticky[3]=1. After the 3rd sample, health is still 1.
3. Same as 2, then one sample of 12'h180 -> sys_health[3]=1; sticky[3] stays 1. Write addr 68 data 16'h0008 -> sticky reads 0.
4. Set unsafe_mask bit 3 (addr 66 = 16'h0008); repeat the violation -> unsafe_sys_health=1 three cycles after the 4th strobe. Clear the mask -> unsafe_sys_health=0.
5. Write addr 70 = 0; send 8 violating samples on ch5 -> no health change. Re-enable: the counter resumes from its held value.
6. Threshold write to ch3 in the same cycle as a ch3 strobe -> the sample is judged with the old thresholds. Assert reset mid-stream -> all outputs return to reset values.
